cla_pipe_addsub: RTL and testbench

// - Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU; next generation of the fixed 16-bit ripple-of-4-bit-CLA adder.
// - Operand width, lookahead group size and pipeline depth are set at elaboration.
// - valid/ready handshake with full backpressure; one operation per cycle sustained; carry, overflow and zero flags registered with the result.

---
 rtl/cla_pipe_addsub.sv | 121 ++++++++++++
 tb/tb_cla_pipe_addsub.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready backpressure.
// Each register stage resolves NGRP/STAGES lookahead groups, then hands the remaining carry on.
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int GPS  = NGRP / STAGES;

  // Index 0 of each *_src/vld_pipe is the prepped input; index k is stage register k.
  logic [STAGES:0]            vld_pipe, c_src;
  logic [STAGES:0][WIDTH-1:0] a_src, b_src, s_src;
  logic [STAGES:1]            vld_q, c_q, c_d, rdy;
  logic [STAGES:1][WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic                       ovf_q, zero_q, ovf_d, zero_d;
  logic                       full, cc;

  // One lookahead group: internal bit carries plus group GG/GP for the carry out.
  function automatic logic [GROUP:0] grp_add(input logic [GROUP-1:0] x, y, input logic ci);
    logic [GROUP-1:0] g, p, s;
    logic             gg, c;
    g  = x & y;
    p  = x ^ y;
    gg = 1'b0;
    c  = ci;
    s  = '0;
    for (int i = 0; i < GROUP; i++) begin
      s[i] = p[i] ^ c;
      c    = g[i] | (p[i] & c);
      gg   = g[i] | (p[i] & gg);
    end
    return {gg | ((&p) & ci), s};
  endfunction

  assign vld_pipe = {vld_q, in_valid};
  assign a_src    = {a_q, a};
  assign b_src    = {b_q, sub ? ~b : b};
  assign c_src    = {c_q, cin ^ sub};
  assign s_src    = {s_q, {WIDTH{1'b0}}};

  // Stage k may load unless it and every stage after it are full and the sink stalls.
  always_comb begin
    rdy  = '0;
    full = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j <= STAGES; j++) full = full & vld_q[j];
      rdy[k] = out_ready | ~full;
    end
  end

  always_comb begin
    s_d = '0;
    c_d = '0;
    cc  = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      s_d[k] = s_src[k-1];
      cc     = c_src[k-1];
      for (int j = 0; j < GPS; j++) begin
        {cc, s_d[k][((k-1)*GPS+j)*GROUP +: GROUP]} =
          grp_add(a_src[k-1][((k-1)*GPS+j)*GROUP +: GROUP],
                  b_src[k-1][((k-1)*GPS+j)*GROUP +: GROUP], cc);
      end
      c_d[k] = cc;
    end
    ovf_d  = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
             (s_d[STAGES][WIDTH-1] != a_src[STAGES-1][WIDTH-1]);
    zero_d = ~|s_d[STAGES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_pipe[k-1];
          a_q[k]   <= a_src[k-1];
          b_q[k]   <= b_src[k-1];
          s_q[k]   <= s_d[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (rdy[STAGES]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: directed flag cases, streaming, stalls, mid-flight reset.
module tb_cla_pipe_addsub;
  localparam int W = 16, G = 4, S = 2;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         out_valid, out_ready = 1'b0, cout, overflow, zero;

  typedef struct packed {logic [W-1:0] s; logic c; logic o; logic z;} exp_t;
  exp_t sb[$];
  int   n_cmp = 0, n_err = 0;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic exp_t model(input logic [W-1:0] x, y, input logic ci, sv);
    logic [W:0] full;
    exp_t e;
    if (!sv) begin
      full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      e.o  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, ~y} + (W+1)'(!ci);
      e.o  = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
    end
    e.s = full[W-1:0];
    e.c = full[W];
    e.z = (full[W-1:0] == '0);
    return e;
  endfunction

  // Drives one cycle's inputs mid-cycle; acc reports whether the beat will transfer.
  task automatic step(input logic iv, input logic [W-1:0] av, bv, input logic ci, sv, ordy,
                      output logic acc);
    @(negedge clk);
    in_valid = iv; a = av; b = bv; cin = ci; sub = sv; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({out_valid, sum, cout, overflow, zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", {out_valid, sum, cout, overflow, zero});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta[5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
    logic [W-1:0] tb[5] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001};
    logic [W-1:0] tr[5] = '{16'h0000, 16'h8000, 16'h5556, 16'hFFFE, 16'h7FFF};
    logic tc[5] = '{0, 0, 1, 0, 0};
    logic ts[5] = '{0, 0, 0, 1, 1};
    logic tco[5] = '{1, 0, 0, 0, 1};
    logic tov[5] = '{0, 1, 0, 0, 1};
    logic tz[5]  = '{1, 0, 0, 0, 0};
    logic acc;
    int   lat;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, acc);
      n_cmp++;
      if (!acc) begin n_err++; $display("FAIL directed_accept[%0d] got 0 want 1", i); end
      sb.push_back({tr[i], tco[i], tov[i], tz[i]});
      lat = 0;
      do begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        lat++;
      end while (!out_valid && lat < 10);
      n_cmp++;
      if (lat != S) begin n_err++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, S); end
      if (out_valid && sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({sum, cout, overflow, zero} !== e) begin
          n_err++;
          $display("FAIL directed_result[%0d] got %h/%b%b%b want %h/%b%b%b",
                   i, sum, cout, overflow, zero, e.s, e.c, e.o, e.z);
        end
      end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL directed_single[%0d] got vld=1 want 0", i); end
    end
    sb.delete();
  endtask

  task automatic test_back_to_back;
    logic acc;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    int   first = -1, last = -1, nout = 0;
    exp_t e;
    for (int cyc = 0; cyc < 8 + S + 3; cyc++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      step(cyc < 8, ra, rb, rc, rs, 1'b1, acc);
      if (cyc < 8) begin
        n_cmp++;
        if (!acc) begin n_err++; $display("FAIL b2b_in_ready[%0d] got 0 want 1", cyc); end
        else sb.push_back(model(ra, rb, rc, rs));
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL b2b_extra got output want none"); end
        else begin
          e = sb.pop_front();
          if ({sum, cout, overflow, zero} !== e) begin
            n_err++;
            $display("FAIL b2b_result got %h/%b%b%b want %h/%b%b%b",
                     sum, cout, overflow, zero, e.s, e.c, e.o, e.z);
          end
        end
      end
    end
    n_cmp++;
    if (nout != 8 || last - first != 7) begin
      n_err++;
      $display("FAIL b2b_consecutive got %0d outs over %0d cycles want 8 over 8", nout, last - first + 1);
    end
  endtask

  task automatic test_backpressure;
    logic acc;
    logic [W-1:0] ra, rb;
    logic rc, rs, held_ok;
    logic [W+2:0] held;
    int   nacc = 0, ndrain = 0, guard = 0;
    exp_t e;
    held_ok = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      step(1'b1, ra, rb, rc, rs, 1'b0, acc);
      if (acc) begin nacc++; sb.push_back(model(ra, rb, rc, rs)); end
      if (out_valid) begin
        if (held_ok) begin
          n_cmp++;
          if ({sum, cout, overflow, zero} !== held) begin
            n_err++;
            $display("FAIL stall_hold got %h want %h", {sum, cout, overflow, zero}, held);
          end
        end
        held = {sum, cout, overflow, zero};
        held_ok = 1'b1;
      end
    end
    n_cmp++;
    if (nacc != S) begin n_err++; $display("FAIL stall_accepts got %0d want %0d", nacc, S); end
    do begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      guard++;
      if (out_valid) begin
        ndrain++;
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL drain_extra got output want none"); end
        else begin
          e = sb.pop_front();
          if ({sum, cout, overflow, zero} !== e) begin
            n_err++;
            $display("FAIL drain_result got %h/%b%b%b want %h/%b%b%b",
                     sum, cout, overflow, zero, e.s, e.c, e.o, e.z);
          end
        end
      end
    end while ((out_valid || sb.size() > 0) && guard < 20);
    n_cmp++;
    if (ndrain != S) begin n_err++; $display("FAIL drain_count got %0d want %0d", ndrain, S); end
  endtask

  task automatic test_random_stall;
    logic acc, iv, ordy;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    int   guard = 0;
    exp_t e;
    for (int cyc = 0; cyc < 200 || ((sb.size() > 0 || out_valid) && guard < 50); cyc++) begin
      if (cyc >= 200) guard++;
      iv   = (cyc < 200) && ($urandom_range(3) != 0);
      ordy = (cyc >= 200) || ($urandom_range(2) != 0);
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      step(iv, ra, rb, rc, rs, ordy, acc);
      if (acc) sb.push_back(model(ra, rb, rc, rs));
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL random_extra got output want none"); end
        else begin
          e = sb.pop_front();
          if ({sum, cout, overflow, zero} !== e) begin
            n_err++;
            $display("FAIL random_result got %h/%b%b%b want %h/%b%b%b",
                     sum, cout, overflow, zero, e.s, e.c, e.o, e.z);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL random_lost got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_reset_midflight;
    logic acc;
    int   lat;
    exp_t e;
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL midflight_loaded got vld=%b want 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, sum, cout, overflow, zero} !== '0) begin
      n_err++;
      $display("FAIL midflight_reset got %h want 0", {out_valid, sum, cout, overflow, zero});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 1'b1, acc);
    if (acc) sb.push_back(model(16'h00F0, 16'h0F0F, 1'b1, 1'b0));
    lat = 0;
    do begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
      lat++;
    end while (!out_valid && lat < 10);
    n_cmp++;
    if (lat != S || sb.size() != 1) begin
      n_err++;
      $display("FAIL restart_latency got %0d (q=%0d) want %0d (q=1)", lat, sb.size(), S);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({sum, cout, overflow, zero} !== e) begin
        n_err++;
        $display("FAIL restart_result got %h want %h", {sum, cout, overflow, zero}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
